lcd_ctrl: RTL
=============

LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter SETUP_CYC, default 2: cycles RS/DATA stay stable before EN rises.
REQ-002 Parameter PULSE_CYC, default 12: cycles EN is held high.
REQ-003 Parameter HOLD_CYC, default 2: cycles RS/DATA are held after EN falls.
REQ-004 Parameter EXEC_CYC, default 2000: execution wait for normal commands and data.
REQ-005 Parameter CLEAR_CYC, default 82000: execution wait for clear (0x01) and home (0x02, 0x03) commands.
REQ-006 Port i_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 Port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port i_wr, input, 1 bit: one-cycle write strobe from the core's LCD I/O register.
REQ-009 Port i_wdata, input, 32 bits: [31]=ON, [30]=ON_ONLY, [9]=RS, [7:0]=DATA; other bits are ignored.
REQ-010 Port i_status_clr, input, 1 bit: clears the overrun flag.
REQ-011 Port o_status, output, 32 bits: [0]=busy, [1]=overrun, [2]=queue full, [31]=ON; other bits are 0.
REQ-012 Port o_lcd_data, output, 8 bits: panel data bus.
REQ-013 Port o_lcd_rs, output, 1 bit: register select.
REQ-014 Port o_lcd_rw, output, 1 bit: read/write; tied to 0.
REQ-015 Port o_lcd_en, output, 1 bit: enable strobe.
REQ-016 Port o_lcd_on, output, 1 bit: panel power/backlight.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP, PULSE, HOLD, EXEC.
REQ-018 An accepted write with ON_ONLY=1 SHALL update o_lcd_on on the next edge only, with no bus transaction.
REQ-019 An accepted write with ON_ONLY=0 SHALL update o_lcd_on on the next edge and enqueue {RS, DATA}.
REQ-020 From IDLE with a pending command: load o_lcd_rs/o_lcd_data on the next edge, then SETUP for SETUP_CYC cycles.
REQ-021 SETUP->PULSE: o_lcd_en=1 for PULSE_CYC cycles.
REQ-022 PULSE->HOLD: o_lcd_en=0, bus unchanged for HOLD_CYC cycles.
REQ-023 HOLD->EXEC: wait CLEAR_CYC cycles if RS=0 and DATA is in 0x01..0x03, otherwise EXEC_CYC cycles.
REQ-024 EXEC->IDLE after the wait; o_lcd_rs/o_lcd_data keep their last values in IDLE.
REQ-025 The countdown counter SHALL be $clog2(max parameter + 1) bits and reload on each state entry.
REQ-026 Any parameter value of 0 SHALL be treated as 1 cycle.
REQ-027 busy SHALL be 1 whenever the state is not IDLE or a command is pending.
REQ-028 i_wr while no command can be accepted SHALL drop the write (o_lcd_on unchanged) and set overrun.
REQ-029 If overrun set and i_status_clr occur in the same cycle, set SHALL win.
REQ-030 A command is issued from IDLE on the edge after it is enqueued (back-to-back issue, no idle gap).

Reset
REQ-031 Asserting i_reset low SHALL immediately force: state=IDLE, counter=0, queue empty, overrun=0.
REQ-032 During reset all o_lcd_* outputs and o_status SHALL be 0.
REQ-033 Reset asserted mid-pulse SHALL drop o_lcd_en asynchronously and discard the in-flight command.

Configuration
REQ-034 With LCD_CTRL_FIFO_EN defined, commands SHALL queue in a 4-entry FIFO.
REQ-035 With the FIFO: a write is accepted iff not full; full=(count==4); simultaneous push and pop on a full FIFO is rejected.
REQ-036 Without LCD_CTRL_FIFO_EN, a single holding register is used.
REQ-037 Without the FIFO: a write is accepted only when the state is IDLE and the register is empty; o_status[2] reads busy.

Structure
REQ-038 Package lcd_pkg SHALL hold the state enum, the i_wdata/o_status bit-position localparams and the clear/home opcode constants.
REQ-039 Sub-module lcd_cmd_fifo (depth 4, width 9, pointer wrap-around) SHALL be instantiated only under LCD_CTRL_FIFO_EN.

Verification (bench overrides SETUP=2, PULSE=3, HOLD=1, EXEC=5, CLEAR=20)
REQ-040 Write 0x0000_0241 from idle -> RS=1, DATA=0x41 on next edge; EN high exactly 3 cycles after 2 setup cycles; busy clears after 2+3+1+5 cycles.
REQ-041 Write 0x0000_0001 -> EXEC lasts 20 cycles; busy=1 throughout the transaction.
REQ-042 Write 0xC000_0000 -> o_lcd_on=1 next edge; EN never rises; busy stays 0.
REQ-043 FIFO build: 6 writes on consecutive cycles from idle -> writes 1-5 issued in order, 6th dropped, overrun=1; i_status_clr clears it. Non-FIFO build: second write dropped, overrun=1.
REQ-044 Assert i_reset low mid-PULSE -> o_lcd_en=0 without waiting for a clock edge; after release, IDLE with o_status=0.
REQ-045 Write issued while overrun set, together with i_status_clr -> overrun remains 1 (set wins).

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD panel controller: state encoding, register
// bit positions, long-running opcodes and small elaboration-time helpers.
package lcd_pkg;

  typedef logic [2:0] lcd_state_t;

  localparam lcd_state_t S_IDLE  = 3'd0;
  localparam lcd_state_t S_SETUP = 3'd1;
  localparam lcd_state_t S_PULSE = 3'd2;
  localparam lcd_state_t S_HOLD  = 3'd3;
  localparam lcd_state_t S_EXEC  = 3'd4;

  localparam int WD_ON      = 31;
  localparam int WD_ON_ONLY = 30;
  localparam int WD_RS      = 9;

  localparam int STS_BUSY = 0;
  localparam int STS_OVR  = 1;
  localparam int STS_FULL = 2;
  localparam int STS_ON   = 31;

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_cmd_t;

  // Clear and home take far longer inside the panel than any other command.
  function automatic logic is_long_cmd(input lcd_cmd_t cmd);
    return !cmd.rs && (cmd.data == OP_CLEAR || cmd.data == OP_HOME ||
                       cmd.data == OP_HOME_ALT);
  endfunction

  function automatic int eff_cyc(input int cyc);
    return (cyc < 1) ? 1 : cyc;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small command FIFO for the LCD controller; pointers wrap explicitly so the
// depth need not be a power of two. Push is ignored when full, pop when empty.
module lcd_cmd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_rdata = mem_q[rd_ptr_q];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/lcd_ctrl.sv
// LCD panel controller: turns core register writes into timed RS/DATA/EN bus
// cycles. Define LCD_CTRL_FIFO_EN for a 4-deep command FIFO instead of one
// holding register.
//
// state | meaning
// IDLE  | bus parked, waiting for a queued command
// SETUP | RS/DATA driven, EN low, address setup time
// PULSE | EN high
// HOLD  | EN low, RS/DATA held
// EXEC  | panel executing the command, bus untouched
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 12,
  parameter int HOLD_CYC  = 2,
  parameter int EXEC_CYC  = 2000,
  parameter int CLEAR_CYC = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr,
  input  logic [31:0] i_wdata,
  input  logic        i_status_clr,
  output logic [31:0] o_status,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on
);

  localparam int MAX_CYC = max_int(max_int(max_int(eff_cyc(SETUP_CYC), eff_cyc(PULSE_CYC)),
                                           max_int(eff_cyc(HOLD_CYC), eff_cyc(EXEC_CYC))),
                                   eff_cyc(CLEAR_CYC));
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  // Each state lasts load+1 cycles, so a zero parameter still gives one cycle.
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(eff_cyc(SETUP_CYC) - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(eff_cyc(PULSE_CYC) - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(eff_cyc(HOLD_CYC) - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(eff_cyc(EXEC_CYC) - 1);
  localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(eff_cyc(CLEAR_CYC) - 1);

  lcd_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_tc;
  logic             rs_q, en_q, on_q, ovr_q;
  logic [7:0]       data_q;
  lcd_cmd_t         wr_cmd, head_cmd;
  logic             can_accept, accept, drop, push, pending, issue, busy, q_full;
  logic             unused_wdata;

  assign wr_cmd       = {i_wdata[WD_RS], i_wdata[7:0]};
  assign accept       = i_wr && can_accept;
  assign drop         = i_wr && !can_accept;
  assign push         = accept && !i_wdata[WD_ON_ONLY];
  assign issue        = (state_q == S_IDLE) && pending;
  assign busy         = (state_q != S_IDLE) || pending;
  assign cnt_tc       = (cnt_q == '0);
  assign unused_wdata = ^{i_wdata[29:10], i_wdata[8]};

`ifdef LCD_CTRL_FIFO_EN
  logic       fifo_empty, fifo_full;
  logic [8:0] fifo_rdata;

  lcd_cmd_fifo #(
    .WIDTH (9),
    .DEPTH (4)
  ) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push),
    .i_pop   (issue),
    .i_wdata (wr_cmd),
    .o_rdata (fifo_rdata),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  assign can_accept = !fifo_full;
  assign pending    = !fifo_empty;
  assign head_cmd   = lcd_cmd_t'(fifo_rdata);
  assign q_full     = fifo_full;
`else
  lcd_cmd_t hold_q;
  logic     hold_vld_q;

  // Accept only into an idle, empty slot, so push and issue never coincide.
  assign can_accept = (state_q == S_IDLE) && !hold_vld_q;
  assign pending    = hold_vld_q;
  assign head_cmd   = hold_q;
  assign q_full     = busy;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else if (push) begin
      hold_q     <= wr_cmd;
      hold_vld_q <= 1'b1;
    end else if (issue) begin
      hold_vld_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pending) begin
            state_q <= S_SETUP;
            cnt_q   <= LD_SETUP;
            rs_q    <= head_cmd.rs;
            data_q  <= head_cmd.data;
          end
        end
        S_SETUP: begin
          if (cnt_tc) begin
            state_q <= S_PULSE;
            cnt_q   <= LD_PULSE;
            en_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (cnt_tc) begin
            state_q <= S_HOLD;
            cnt_q   <= LD_HOLD;
            en_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt_tc) begin
            state_q <= S_EXEC;
            cnt_q   <= is_long_cmd({rs_q, data_q}) ? LD_CLEAR : LD_EXEC;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (cnt_tc) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  // A dropped write sets overrun even if software clears it in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      on_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      if (accept) on_q <= i_wdata[WD_ON];
      if (drop) begin
        ovr_q <= 1'b1;
      end else if (i_status_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  always_comb begin
    o_status           = '0;
    o_status[STS_BUSY] = busy;
    o_status[STS_OVR]  = ovr_q;
    o_status[STS_FULL] = q_full;
    o_status[STS_ON]   = on_q;
  end

  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_on   = on_q;

endmodule
